// File: rtl/gram_matrix_2x2_if.sv
// Stream interface between the channel-column feeder, the Gram accumulator and the 2x2 inverter.
// The slave side is the accumulator; the master side is the test/upstream/downstream environment.
interface gram_matrix_2x2_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 64
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] h0;
  logic signed [DATA_W-1:0] h1;
  logic                     out_valid;
  logic                     out_ready;
  logic        [ACC_W-1:0]  g_0;
  logic        [ACC_W-1:0]  g_1;
  logic        [ACC_W-1:0]  g_2;
  logic        [ACC_W-1:0]  g_3;

  modport slave (
    input  in_valid, h0, h1, out_ready,
    output in_ready, out_valid, g_0, g_1, g_2, g_3
  );

  modport master (
    output in_valid, h0, h1, out_ready,
    input  in_ready, out_valid, g_0, g_1, g_2, g_3
  );
endinterface

// File: rtl/gram_matrix_2x2.sv
// Accumulates G = H*H^T over N_ANT channel columns and presents it row-major to the 2x2 inverter.
// Define GRAM_REG_EN to add LAMBDA to both diagonal terms (MMSE regularisation).
module gram_matrix_2x2 #(
  parameter int          DATA_W = 16,
  parameter int          N_ANT  = 4,
  parameter int          ACC_W  = 64,
  parameter int unsigned LAMBDA = 0
) (
  input  logic              clk,
  input  logic              reset,
  gram_matrix_2x2_if.slave  bus,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_e;

  localparam int          PROD_W = 2 * DATA_W;
  localparam int          EXT_W  = ACC_W - PROD_W;
  localparam logic [15:0] N_LAST = 16'(N_ANT);

  state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc00_q, acc00_d, acc01_q, acc01_d, acc11_q, acc11_d;
  logic signed [ACC_W-1:0] g00_q, g00_d, g01_q, g01_d, g11_q, g11_d;

  logic signed [DATA_W-1:0] h0_s, h1_s;
  logic signed [PROD_W-1:0] p00, p01, p11;
  logic signed [ACC_W-1:0]  x00, x01, x11;
  logic signed [ACC_W-1:0]  sum00, sum01, sum11;
  logic                     beat, last_beat;

  assign h0_s = bus.h0;
  assign h1_s = bus.h1;
  assign p00  = h0_s * h0_s;
  assign p01  = h0_s * h1_s;
  assign p11  = h1_s * h1_s;
  assign x00  = {{EXT_W{p00[PROD_W-1]}}, p00};
  assign x01  = {{EXT_W{p01[PROD_W-1]}}, p01};
  assign x11  = {{EXT_W{p11[PROD_W-1]}}, p11};

  // The first beat of a matrix starts from zero so stale sums never leak into a new matrix.
  assign sum00 = ((state_q == IDLE) ? '0 : acc00_q) + x00;
  assign sum01 = ((state_q == IDLE) ? '0 : acc01_q) + x01;
  assign sum11 = ((state_q == IDLE) ? '0 : acc11_q) + x11;

  assign beat      = bus.in_valid & bus.in_ready;
  assign last_beat = beat && ((cnt_q + 16'd1) == N_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (beat) state_d = last_beat ? OUT : ACCUM;
      ACCUM:   if (last_beat) state_d = OUT;
      OUT:     if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    acc00_d = acc00_q;
    acc01_d = acc01_q;
    acc11_d = acc11_q;
    g00_d   = g00_q;
    g01_d   = g01_q;
    g11_d   = g11_q;
    if (beat) begin
      cnt_d   = cnt_q + 16'd1;
      acc00_d = sum00;
      acc01_d = sum01;
      acc11_d = sum11;
    end
    if (last_beat) begin
`ifdef GRAM_REG_EN
      g00_d = sum00 + ACC_W'(LAMBDA);
      g11_d = sum11 + ACC_W'(LAMBDA);
`else
      g00_d = sum00;
      g11_d = sum11;
`endif
      g01_d = sum01;
    end
    if ((state_q == OUT) && bus.out_ready) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      acc00_q <= '0;
      acc01_q <= '0;
      acc11_q <= '0;
      g00_q   <= '0;
      g01_q   <= '0;
      g11_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      acc00_q <= acc00_d;
      acc01_q <= acc01_d;
      acc11_q <= acc11_d;
      g00_q   <= g00_d;
      g01_q   <= g01_d;
      g11_q   <= g11_d;
    end
  end

  // in_ready is gated by reset so nothing is taken while the block is held in reset.
  always_comb begin
    bus.in_ready  = reset && (state_q != OUT);
    bus.out_valid = (state_q == OUT);
    busy          = (state_q != IDLE);
    bus.g_0       = g00_q;
    bus.g_1       = g01_q;
    bus.g_2       = g01_q;
    bus.g_3       = g11_q;
  end

endmodule

// File: tb/tb_gram_matrix_2x2.sv
// Randomised and directed bench for gram_matrix_2x2 against a sum-of-products reference model.
// Build with GRAM_REG_EN defined to exercise the regularised diagonal (LAMBDA = 5).
module tb_gram_matrix_2x2;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 64;
  localparam int N_ANT  = 4;
`ifdef GRAM_REG_EN
  localparam longint LAM = 5;
`else
  localparam longint LAM = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic busy;

  logic                     in_valid_drv  = 1'b0;
  logic signed [DATA_W-1:0] h0_drv        = '0;
  logic signed [DATA_W-1:0] h1_drv        = '0;
  logic                     out_ready_drv = 1'b0;

  int n_vectors     = 0;
  int n_miscompares = 0;

  int a_vec[4];
  int b_vec[4];

  longint m_s00 = 0, m_s01 = 0, m_s11 = 0;
  longint m_g0 = 0, m_g1 = 0, m_g3 = 0;
  int     m_cnt = 0;
  bit     m_pending = 1'b0;

  gram_matrix_2x2_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

  assign bus.in_valid  = in_valid_drv;
  assign bus.h0        = h0_drv;
  assign bus.h1        = h1_drv;
  assign bus.out_ready = out_ready_drv;

  gram_matrix_2x2 #(
    .DATA_W(DATA_W),
    .N_ANT (N_ANT),
    .ACC_W (ACC_W),
    .LAMBDA(5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    n_vectors++;
    if (act != exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: a matrix is complete after N_ANT accepted beats and is held until consumed.
  always @(negedge clk) begin
    if (!reset) begin
      m_s00 = 0; m_s01 = 0; m_s11 = 0;
      m_g0 = 0; m_g1 = 0; m_g3 = 0;
      m_cnt = 0;
      m_pending = 1'b0;
    end
    checkOutput("cyc_in_ready",  longint'(bus.in_ready),  longint'(reset && !m_pending));
    checkOutput("cyc_out_valid", longint'(bus.out_valid), longint'(m_pending));
    checkOutput("cyc_busy",      longint'(busy),          longint'(m_pending || (m_cnt > 0)));
    checkOutput("cyc_g_0", $signed(bus.g_0), m_g0);
    checkOutput("cyc_g_1", $signed(bus.g_1), m_g1);
    checkOutput("cyc_g_2", $signed(bus.g_2), m_g1);
    checkOutput("cyc_g_3", $signed(bus.g_3), m_g3);
    if (reset) begin
      if (m_pending) begin
        if (out_ready_drv) begin
          m_pending = 1'b0;
          m_cnt = 0;
        end
      end else if (in_valid_drv) begin
        m_s00 += longint'(h0_drv) * longint'(h0_drv);
        m_s01 += longint'(h0_drv) * longint'(h1_drv);
        m_s11 += longint'(h1_drv) * longint'(h1_drv);
        m_cnt++;
        if (m_cnt == N_ANT) begin
          m_g0 = m_s00 + LAM;
          m_g1 = m_s01;
          m_g3 = m_s11 + LAM;
          m_s00 = 0; m_s01 = 0; m_s11 = 0;
          m_cnt = 0;
          m_pending = 1'b1;
        end
      end
    end
  end

  task automatic applyStimulus(input int a, input int b, input int gap);
    in_valid_drv = 1'b1;
    h0_drv = DATA_W'(a);
    h1_drv = DATA_W'(b);
    @(posedge clk); #1;
    in_valid_drv = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic sendMatrix(input int max_gap);
    for (int i = 0; i < 4; i++)
      applyStimulus(a_vec[i], b_vec[i], (i == 3) ? 0 : $urandom_range(0, max_gap));
  endtask

  task automatic checkMatrix(input string tag, input longint e0, input longint e1, input longint e3);
    int waited = 0;
    @(negedge clk);
    while (!bus.out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, "_out_valid"}, longint'(bus.out_valid), 1);
    checkOutput({tag, "_g_0"}, $signed(bus.g_0), e0);
    checkOutput({tag, "_g_1"}, $signed(bus.g_1), e1);
    checkOutput({tag, "_g_2"}, $signed(bus.g_2), e1);
    checkOutput({tag, "_g_3"}, $signed(bus.g_3), e3);
  endtask

  task automatic resetCycles(input int n);
    reset = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
  endtask

  initial begin
    $display("[TB] start, N_ANT=%0d, diagonal offset %0d", N_ANT, LAM);
    @(posedge clk); #1;
    resetCycles(2);
    @(negedge clk);
    checkOutput("rst_in_ready", longint'(bus.in_ready), 1);
    checkOutput("rst_g_0", $signed(bus.g_0), 0);
    @(posedge clk); #1;

    out_ready_drv = 1'b1;
    a_vec = '{1, 2, 3, 4};
    b_vec = '{1, 1, 1, 1};
    sendMatrix(0);
    checkMatrix("basic", 30 + LAM, 10, 4 + LAM);
    @(negedge clk);
    checkOutput("basic_after_valid", longint'(bus.out_valid), 0);
    checkOutput("basic_after_ready", longint'(bus.in_ready), 1);
    @(posedge clk); #1;

    a_vec = '{-3, 2, -1, 5};
    b_vec = '{4, -2, 0, 1};
    sendMatrix(0);
    checkMatrix("signed", 39 + LAM, -11, 21 + LAM);
    @(posedge clk); #1;

    out_ready_drv = 1'b0;
    a_vec = '{1, 2, 3, 4};
    b_vec = '{1, 1, 1, 1};
    sendMatrix(0);
    checkMatrix("bp_first", 30 + LAM, 10, 4 + LAM);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++)
      applyStimulus(int'($urandom_range(0, 200)) - 100, int'($urandom_range(0, 200)) - 100, 0);
    checkOutput("bp_held_valid", longint'(bus.out_valid), 1);
    checkOutput("bp_held_g_0", $signed(bus.g_0), 30 + LAM);
    out_ready_drv = 1'b1;
    @(posedge clk); #1;
    a_vec = '{1, 1, 1, 1};
    sendMatrix(0);
    checkMatrix("bp_second", 4 + LAM, 4, 4 + LAM);
    @(posedge clk); #1;

    a_vec = '{-32768, -32768, -32768, -32768};
    b_vec = '{-32768, -32768, -32768, -32768};
    sendMatrix(3);
    checkMatrix("extreme", 64'sd4294967296 + LAM, 64'sd4294967296, 64'sd4294967296 + LAM);
    @(posedge clk); #1;

    applyStimulus(7, 9, 0);
    applyStimulus(-5, 3, 0);
    resetCycles(2);
    a_vec = '{1, 2, 3, 4};
    b_vec = '{1, 1, 1, 1};
    sendMatrix(1);
    checkMatrix("abort", 30 + LAM, 10, 4 + LAM);
    @(posedge clk); #1;

    for (int cyc = 0; cyc < 600; cyc++) begin
      in_valid_drv  = ($urandom_range(0, 3) != 0);
      h0_drv        = DATA_W'($urandom);
      h1_drv        = DATA_W'($urandom);
      out_ready_drv = ($urandom_range(0, 2) != 0);
      if (cyc == 300) reset = 1'b0;
      if (cyc == 302) reset = 1'b1;
      @(posedge clk); #1;
    end
    in_valid_drv = 1'b0;
    out_ready_drv = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/gram_matrix_2x2.md
Name: gram_matrix_2x2

Overview:
Upstream feeder for the 2x2 matrix inverter in the PCA linear precoder. Streams one channel column per beat (h0 = user-0 coefficient, h1 = user-1 coefficient) over N_ANT antennas. Accumulates the Gram matrix G = H*H^T. Presents G row-major as four 64-bit words (g_0 = G00, g_1 = G01, g_2 = G10, g_3 = G11), which connect directly to the inverter's inp_0..inp_3.

Parameters:
DATA_W, 16, signed width of each channel coefficient h0/h1
N_ANT, 4, beats per Gram matrix (antenna count); legal range 1..65535
ACC_W, 64, accumulator/output width; must be >= 2*DATA_W + 16
LAMBDA, 0, unsigned diagonal regularisation constant; used only with GRAM_REG_EN

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  h0/h1 beat valid
in_ready  out  1  block can accept a beat
h0  in  DATA_W  signed user-0 coefficient for current antenna
h1  in  DATA_W  signed user-1 coefficient for current antenna
out_valid  out  1  g_0..g_3 hold a complete Gram matrix
out_ready  in  1  downstream consumes the matrix
g_0  out  ACC_W  G00 = sum h0*h0
g_1  out  ACC_W  G01 = sum h0*h1
g_2  out  ACC_W  G10, always equal to g_1
g_3  out  ACC_W  G11 = sum h1*h1
busy  out  1  high in ACCUM or OUT

Behaviour:
- Reset (reset = 0, asynchronous): state = IDLE, beat counter = 0, accumulators = 0, g_0..g_3 = 0, out_valid = 0, busy = 0. in_ready is also 0 while reset is asserted. Asserting reset mid-ACCUM or mid-OUT discards partial sums with no output.
- Beat accepted: in_valid & in_ready on a rising clk edge.
- Arithmetic:
  - Products are full-precision signed 2*DATA_W bits, sign-extended to ACC_W before accumulation.
  - Signed two's-complement throughout, no saturation.
  - No overflow is possible within the legal N_ANT and ACC_W.
- State IDLE:
  - in_ready = 1, out_valid = 0.
  - An accepted beat loads the accumulators with its products (no add to stale values) and sets the counter to 1.
  - If N_ANT == 1, go to OUT; otherwise go to ACCUM.
- State ACCUM:
  - in_ready = 1.
  - Each accepted beat adds its products and increments the counter.
  - The beat that makes counter == N_ANT transfers the final sums into g_0..g_3 and moves to OUT.
  - No beat accepted: hold state.
- State OUT:
  - in_ready = 0, out_valid = 1.
  - g_0..g_3 are stable and must not change while out_valid = 1.
  - out_ready = 1: handshake completes that edge; next cycle state = IDLE, out_valid = 0, counter = 0.
  - g_0..g_3 keep their last values after the handshake (not cleared).
- Latency: last beat accepted at edge t gives out_valid = 1 in the cycle after t. Throughput is one matrix per N_ANT+1 cycles at full rate, because the IDLE cycle after the handshake accepts the next first beat.
- in_valid high while in_ready = 0: the beat is ignored, not queued. The upstream must hold it.
- in_valid toggling mid-matrix (gaps) is legal; only accepted beats count.
- out_ready high in IDLE or ACCUM has no effect.
- g_2 is driven from the same register as g_1 (structural symmetry).
- busy = (state != IDLE).

Optional Feature:
GRAM_REG_EN:
- Defined: MMSE-style regularisation. At the OUT transfer, g_0 = sum h0^2 + LAMBDA and g_3 = sum h1^2 + LAMBDA. Off-diagonals are unchanged. LAMBDA is zero-extended to ACC_W.
- Undefined: pure Gram matrix. LAMBDA is ignored and no adder is built.

Test Plan:
- N_ANT=4; h0 = 1,2,3,4 and h1 = 1,1,1,1 on consecutive cycles with out_ready = 1 -> one cycle after the 4th beat out_valid = 1 with g_0=30, g_1=g_2=10, g_3=4; next cycle out_valid = 0 and in_ready = 1.
- Signed case, N_ANT=4; h0 = -3,2,-1,5 and h1 = 4,-2,0,1 -> g_0=39, g_1=g_2=-11, g_3=21 (checked as 64-bit two's complement).
- Backpressure: first matrix with out_ready = 0 for 5 cycles -> out_valid held, g_* stable, in_ready = 0, in_valid beats ignored. out_ready then pulsed -> IDLE, and the second matrix (all h=1) yields g_0=g_1=g_3=4.
- Extreme values: h0 = h1 = -32768 for 4 beats with gaps between beats -> g_0 = g_1 = g_3 = 4294967296, no wrap.
- Reset mid-ACCUM after 2 beats, then release and send the full first vector set -> no out_valid before release; result is 30/10/10/4, with no residue from the aborted sums.
- GRAM_REG_EN defined, LAMBDA=5, first vector set -> g_0=35, g_1=g_2=10, g_3=9.
